fetch_redirect_ctrl: RTL

Sequences PC updates for the IF0 stage. Each cycle it picks the next PC from four candidates: EX-stage branch correction, IF1 predictor redirect, sequential PC+4, or hold. When an EX correction arrives during an ICache miss, it parks the target and replays it when the ICache frees up, then kills the wrong-path fetch. It sits between the predictor, the EX branch unit, the cache stall sources and the PC register, and takes over the stall/priority decision from the fetch stage.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 11 +
 rtl/redirect_cnt_sat.sv | 31 +++
 rtl/fetch_redirect_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared CPU fetch parameters: datapath width and redirect FSM state encoding.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned WORD = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } redir_state_e;

endpackage

// File: rtl/redirect_cnt_sat.sv
// Saturating event counter: counts increment requests, sticks at all-ones.
module redirect_cnt_sat #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF0 next-PC selection: EX correction, predictor redirect, PC+4 or hold, with an
// EX target parked across ICache misses and replayed when the cache frees up.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORD-1:0]  pc_cur,
  input  logic             pre_branch,
  input  logic [WORD-1:0]  pre_pc,
  input  logic             ex_branch,
  input  logic [WORD-1:0]  ex_pc,
  input  logic             icache_stall,
  input  logic             load_stall,
  input  logic             dcache_stall,
  output logic [WORD-1:0]  npc,
  output logic             pc_we,
  output logic             flush_if,
  output logic             flush_id,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  redir_state_e    state_q, state_d;
  logic [WORD-1:0] pend_pc_q, pend_pc_d;
  logic            bstall;
  logic            cnt_inc;

  assign bstall = load_stall | dcache_stall;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    npc       = pc_cur;
    pc_we     = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_branch && !icache_stall) begin
          npc      = ex_pc;
          pc_we    = 1'b1;
          flush_if = 1'b1;
          flush_id = 1'b1;
          cnt_inc  = 1'b1;
        end else if (ex_branch) begin
          pend_pc_d = ex_pc;
          flush_if  = 1'b1;
          flush_id  = 1'b1;
          state_d   = StWait;
        end else if (icache_stall || bstall) begin
          pc_we = 1'b0;
        end else if (pre_branch) begin
          npc   = pre_pc;
          pc_we = 1'b1;
        end else begin
          npc   = pc_cur + WORD'(4);
          pc_we = 1'b1;
        end
      end
      StWait: begin
        // Predictor redirects are ignored here: the parked target is authoritative.
        if (ex_branch) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          if (icache_stall) begin
            pend_pc_d = ex_pc;
          end else begin
            npc     = ex_pc;
            pc_we   = 1'b1;
            cnt_inc = 1'b1;
            state_d = StIdle;
          end
        end else if (!icache_stall) begin
          // flush_if drops the wrong-path line returning from the miss.
          npc      = pend_pc_q;
          pc_we    = 1'b1;
          flush_if = 1'b1;
          cnt_inc  = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!rst) begin
      npc      = pc_cur;
      pc_we    = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
      cnt_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign redirect_pending = (state_q == StWait);

  redirect_cnt_sat #(
    .CNT_W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .count (redirect_cnt)
  );

endmodule
